// File: rtl/tx_fsrc_seq_ctrl.sv
// Sequencing controller for the TX FSRC hole-insertion stage: serial seed calculation,
// optional trigger alignment, programmable start delay, and one-cycle control pulses.
module tx_fsrc_seq_ctrl #(
  parameter int unsigned NUM_SAMPLES = 16,
  parameter int unsigned ACCUM_WIDTH = 64,
  parameter int unsigned DELAY_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      enable,
  input  logic                                      start_req,
  input  logic                                      stop_req,
  input  logic                                      ext_trig,
  input  logic                                      trig_mode,
  input  logic [DELAY_WIDTH-1:0]                    start_delay,
  input  logic [ACCUM_WIDTH-1:0]                    accum_init,
  input  logic [ACCUM_WIDTH-1:0]                    accum_add_val,
  output logic [NUM_SAMPLES-1:0][ACCUM_WIDTH-1:0]   accum_set_val,
  output logic                                      accum_set,
  output logic                                      fsrc_data_start,
  output logic                                      fsrc_stop,
  output logic                                      busy,
  output logic                                      running
);

  localparam int unsigned LaneW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    StIdle, StCalc, StArmed, StDelay, StSet, StStart, StRun, StStop
  } state_e;

  state_e                                   state_q, state_d;
  logic [LaneW-1:0]                         lane_q, lane_d;
  logic [ACCUM_WIDTH-1:0]                   sum_q, sum_d;
  logic [ACCUM_WIDTH-1:0]                   add_q, add_d;
  logic                                     mode_q, mode_d;
  logic [DELAY_WIDTH-1:0]                   dly_q, dly_d;
  logic [DELAY_WIDTH-1:0]                   cnt_q, cnt_d;
  logic [NUM_SAMPLES-1:0][ACCUM_WIDTH-1:0]  seed_q;
  logic                                     seed_we;
  logic                                     abort;

  assign abort = stop_req | ~enable;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    sum_d   = sum_q;
    add_d   = add_q;
    mode_d  = mode_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    seed_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req && enable && !stop_req) begin
          state_d = StCalc;
          sum_d   = accum_init;
          add_d   = accum_add_val;
          mode_d  = trig_mode;
          dly_d   = start_delay;
          lane_d  = '0;
        end
      end
      StCalc: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          // Running sum: lane i receives init + i*add without a multiplier.
          seed_we = 1'b1;
          sum_d   = sum_q + add_q;
          lane_d  = lane_q + 1'b1;
          if (lane_q == LastLane) state_d = StArmed;
        end
      end
      StArmed: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!mode_q || ext_trig) begin
          if (dly_q == '0) begin
            state_d = StSet;
          end else begin
            state_d = StDelay;
            cnt_d   = dly_q;
          end
        end
      end
      StDelay: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == DELAY_WIDTH'(1)) begin
          state_d = StSet;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSet:   state_d = abort ? StIdle : StStart;
      StStart: state_d = abort ? StIdle : StRun;
      StRun:   if (abort) state_d = StStop;
      StStop:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      lane_q  <= '0;
      sum_q   <= '0;
      add_q   <= '0;
      mode_q  <= 1'b0;
      dly_q   <= '0;
      cnt_q   <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      sum_q   <= sum_d;
      add_q   <= add_d;
      mode_q  <= mode_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      if (seed_we) seed_q[lane_q] <= sum_q;
    end
  end

  // All pulses decode straight from the state register, so each is exactly one cycle wide.
  assign accum_set_val   = seed_q;
  assign accum_set       = (state_q == StSet);
  assign fsrc_data_start = (state_q == StStart);
  assign fsrc_stop       = (state_q == StStop);
  assign busy            = (state_q != StIdle);
  assign running         = (state_q == StRun);

endmodule

// File: tb/tb_tx_fsrc_seq_ctrl.sv
// Scoreboard bench for tx_fsrc_seq_ctrl: each planned run pushes its expected pulses
// (kind, cycle, seeds) into a queue that a negedge monitor drains.
module tb_tx_fsrc_seq_ctrl;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   enable, start_req, stop_req, ext_trig, trig_mode;
  logic [DW-1:0]          start_delay;
  logic [AW-1:0]          accum_init, accum_add_val;
  logic [N-1:0][AW-1:0]   accum_set_val;
  logic                   accum_set, fsrc_data_start, fsrc_stop, busy, running;

  tx_fsrc_seq_ctrl #(
    .NUM_SAMPLES(N),
    .ACCUM_WIDTH(AW),
    .DELAY_WIDTH(DW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .start_req      (start_req),
    .stop_req       (stop_req),
    .ext_trig       (ext_trig),
    .trig_mode      (trig_mode),
    .start_delay    (start_delay),
    .accum_init     (accum_init),
    .accum_add_val  (accum_add_val),
    .accum_set_val  (accum_set_val),
    .accum_set      (accum_set),
    .fsrc_data_start(fsrc_data_start),
    .fsrc_stop      (fsrc_stop),
    .busy           (busy),
    .running        (running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   kind;  // 0 accum_set, 1 data_start, 2 stop
    int                   cyc;
    logic [N-1:0][AW-1:0] seeds;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      ev = exp_q.pop_front();
      chk("pulse_kind", 64'(kind), 64'(ev.kind));
      chk("pulse_cycle", 64'(cyc), 64'(ev.cyc));
      if (kind == 0) chk("seeds", 64'(accum_set_val), 64'(ev.seeds));
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (accum_set)       pop_check(0);
      if (fsrc_data_start) pop_check(1);
      if (fsrc_stop)       pop_check(2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start_req = 1'b0;
    stop_req  = 1'b0;
    enable    = 1'b1;
    ext_trig  = 1'b0;
  endtask

  // endk: 0 stop_req in RUN, 1 enable low in RUN, 2 stop_req before RUN, 3 enable low before RUN.
  task automatic do_run(input logic [AW-1:0] init, input logic [AW-1:0] add, input logic mode,
                        input int d, input int tgap, input logic early, input int endk,
                        input int rgap);
    int   k, t, a, s, last, set_c, start_c;
    ev_t  ev;
    k       = cyc;
    t       = mode ? k + 1 + N + tgap : k + 1 + N;
    set_c   = t + 1 + d;
    start_c = t + 2 + d;
    a       = -1;
    s       = -1;
    for (int i = 0; i < N; i++) ev.seeds[i] = init + AW'(i) * add;
    if (endk < 2) begin
      s    = start_c + 1 + rgap;
      last = s + 1;
    end else begin
      a    = k + 1 + (rgap % (start_c - k));
      last = a;
    end
    if (set_c <= last)   begin ev.kind = 0; ev.cyc = set_c;   exp_q.push_back(ev); end
    if (start_c <= last) begin ev.kind = 1; ev.cyc = start_c; exp_q.push_back(ev); end
    if (endk < 2)        begin ev.kind = 2; ev.cyc = s + 1;   exp_q.push_back(ev); end

    for (int c = k; c <= last; c++) begin
      start_req = (c == k) || (c > k && $urandom_range(3) == 0);
      stop_req  = (endk == 0 && c == s) || (endk == 2 && c == a);
      enable    = !((endk == 1 && c == s) || (endk == 3 && c == a));
      ext_trig  = (mode && c == t) || (early && (c == k + 3 || c == k + N)) ||
                  ((c <= k + N || c > t) && $urandom_range(4) == 0);
      if (c == k) begin
        accum_init    = init;
        accum_add_val = add;
        trig_mode     = mode;
        start_delay   = DW'(d);
      end else begin
        accum_init    = AW'($urandom);
        accum_add_val = AW'($urandom);
        trig_mode     = 1'($urandom_range(1));
        start_delay   = DW'($urandom_range(7));
      end
      if (c == k + 1) chk("busy_calc", 64'(busy), 64'd1);
      if (endk < 2 && c == start_c + 1) chk("running", 64'(running), 64'd1);
      step();
    end
    quiet();
    chk("busy_after", 64'(busy), 64'd0);
    chk("running_after", 64'(running), 64'd0);
    step();
    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    resetn        = 1'b0;
    quiet();
    trig_mode     = 1'b0;
    start_delay   = '0;
    accum_init    = '0;
    accum_add_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_pulses", 64'({accum_set, fsrc_data_start, fsrc_stop}), 64'd0);
    chk("rst_seeds", 64'(accum_set_val), 64'd0);
    resetn = 1'b1;
    step();

    // Immediate start, wrap-around seeds, triggered start with ignored early triggers.
    do_run(16'h1000, 16'h0300, 1'b0, 0, 0, 1'b0, 0, 2);
    do_run(16'hFF00, 16'h0080, 1'b0, 0, 0, 1'b0, 1, 0);
    do_run(16'h1234, 16'h0011, 1'b1, 3, 15, 1'b1, 0, 4);
    // Stop during DELAY; enable dropped during ARMED.
    do_run(16'h2000, 16'h0100, 1'b0, 5, 0, 1'b0, 2, 6);
    do_run(16'h3000, 16'h0200, 1'b1, 2, 6, 1'b0, 3, 5);

    // Start and stop in the same IDLE cycle, and start while disabled.
    start_req = 1'b1;
    stop_req  = 1'b1;
    step();
    quiet();
    chk("start_stop_idle", 64'(busy), 64'd0);
    start_req = 1'b1;
    enable    = 1'b0;
    step();
    quiet();
    chk("start_disabled", 64'(busy), 64'd0);
    step();

    // Asynchronous reset in the middle of DELAY.
    k             = cyc;
    start_req     = 1'b1;
    trig_mode     = 1'b0;
    start_delay   = DW'(6);
    accum_init    = 16'h5555;
    accum_add_val = 16'h0101;
    step();
    quiet();
    while (cyc < k + 8) step();
    chk("busy_in_delay", 64'(busy), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_running", 64'(running), 64'd0);
    chk("async_pulses", 64'({accum_set, fsrc_data_start, fsrc_stop}), 64'd0);
    chk("async_seeds", 64'(accum_set_val), 64'd0);
    step();
    step();
    resetn = 1'b1;
    step();
    do_run(16'h1000, 16'h0300, 1'b0, 0, 0, 1'b0, 0, 1);

    for (int r = 0; r < 30; r++) begin
      do_run(AW'($urandom), AW'($urandom), 1'($urandom_range(1)), int'($urandom_range(4)),
             int'($urandom_range(5)), 1'($urandom_range(1)), int'($urandom_range(3)),
             int'($urandom_range(8)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
